// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// imem_ctrl_pkg : shared constants and FSM encoding for the instruction-SRAM
//                 sequencing controller.
// Revision      : 1.0
// ============================================================================
package imem_ctrl_pkg;

    localparam int IMEM_ADDR_W = 9;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_MASK_W = 4;
    localparam int IMEM_DEPTH  = 512;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } imem_state_e;

endpackage : imem_ctrl_pkg
`default_nettype wire

// File: rtl/imem_ctrl_if.sv
`default_nettype none
// ============================================================================
// imem_ctrl_if : loader, fetch and SRAM-port bundle of the instruction-memory
//                controller; slave = controller side, master = everything else.
// Revision     : 1.0
// ============================================================================
interface imem_ctrl_if
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int MASK_W = IMEM_MASK_W
) ();

    logic              load_mode;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [MASK_W-1:0] ld_wmask;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              core_stall;
    logic [ADDR_W:0]   words_loaded;

    logic              sram_csb0;
    logic              sram_web0;
    logic [ADDR_W-1:0] sram_addr0;
    logic [DATA_W-1:0] sram_din0;
    logic [MASK_W-1:0] sram_wmask0;
    logic              sram_csb1;
    logic [ADDR_W-1:0] sram_addr1;
    logic [DATA_W-1:0] sram_dout1;

    modport slave (
        input  load_mode, ld_valid, ld_addr, ld_data, ld_wmask,
        input  fetch_req, fetch_addr, sram_dout1,
        output ld_ready, fetch_valid, fetch_data, core_stall, words_loaded,
        output sram_csb0, sram_web0, sram_addr0, sram_din0, sram_wmask0,
        output sram_csb1, sram_addr1
    );

    modport master (
        output load_mode, ld_valid, ld_addr, ld_data, ld_wmask,
        output fetch_req, fetch_addr, sram_dout1,
        input  ld_ready, fetch_valid, fetch_data, core_stall, words_loaded,
        input  sram_csb0, sram_web0, sram_addr0, sram_din0, sram_wmask0,
        input  sram_csb1, sram_addr1
    );

endinterface : imem_ctrl_if
`default_nettype wire

// File: rtl/imem_ctrl.sv
`default_nettype none
// ============================================================================
// imem_ctrl : arbitrates the 512x32 instruction SRAM between the host loader
//             (port 0, write) and the core fetch path (port 1, read).
// Revision  : 1.0
// ============================================================================
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int MASK_W = IMEM_MASK_W
) (
    input  wire logic   wb_clk_i,
    input  wire logic   wb_rst_n,
    imem_ctrl_if.slave  bus
);

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    imem_state_e       r_state;
    imem_state_e       w_state_next;
    logic              r_fetch_valid;
    logic              r_core_stall;
    logic [ADDR_W:0]   r_words;

    logic              w_clr_words;
    logic              w_ld_ready;
    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr0;
    logic [DATA_W-1:0] w_din0;
    logic [MASK_W-1:0] w_wmask0;
    logic [ADDR_W-1:0] w_addr1;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr_words  = 1'b0;
        w_ld_ready   = 1'b0;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_rd = bus.fetch_req;
                if (bus.load_mode) begin
                    w_state_next = ST_DRAIN;
                    w_clr_words  = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_ld_ready = 1'b1;
                w_wr       = bus.ld_valid;
                // The closing beat is still accepted alongside the exit decision.
                if (!bus.load_mode) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Stall tracks the state being entered so it is already high in DRAIN.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_fetch_valid <= 1'b0;
            r_core_stall  <= 1'b0;
            r_words       <= '0;
        end else begin
            r_fetch_valid <= w_rd;
            r_core_stall  <= (w_state_next != ST_RUN);
            if (w_clr_words) begin
                r_words <= '0;
            end else if (w_wr && (r_words != c_DEPTH)) begin
                r_words <= r_words + c_ONE;
            end
        end
    end

    assign w_addr0  = w_wr ? bus.ld_addr    : '0;
    assign w_din0   = w_wr ? bus.ld_data    : '0;
    assign w_wmask0 = w_wr ? bus.ld_wmask   : '0;
    assign w_addr1  = w_rd ? bus.fetch_addr : '0;

    // Chip selects are gated by reset so a reset cycle never touches the array.
    assign bus.sram_csb0    = !(wb_rst_n && w_wr);
    assign bus.sram_web0    = !(wb_rst_n && w_wr);
    assign bus.sram_addr0   = w_addr0;
    assign bus.sram_din0    = w_din0;
    assign bus.sram_wmask0  = w_wmask0;
    assign bus.sram_csb1    = !(wb_rst_n && w_rd);
    assign bus.sram_addr1   = w_addr1;

    assign bus.ld_ready     = wb_rst_n && w_ld_ready;
    assign bus.fetch_valid  = r_fetch_valid;
    assign bus.fetch_data   = bus.sram_dout1;
    assign bus.core_stall   = r_core_stall;
    assign bus.words_loaded = r_words;

endmodule : imem_ctrl
`default_nettype wire

// File: tb/tb_imem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_imem_ctrl : directed + randomized bench with an SRAM model and a
//                word-level expected-memory reference.
// Revision     : 1.0
// ============================================================================
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic preload;

    imem_ctrl_if bus ();

    imem_ctrl dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] init_mem [IMEM_DEPTH];
    logic [31:0] sram_mem [IMEM_DEPTH];
    logic [31:0] exp_mem  [IMEM_DEPTH];

    int n_checks = 0;
    int n_err    = 0;
    int beats    = 0;

    logic [8:0]  a;
    logic [31:0] d;
    logic        r;

    // Macro model: registered read on port 1, byte-masked write on port 0.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < IMEM_DEPTH; i++) sram_mem[i] <= init_mem[i];
        end else if (!bus.sram_csb0 && !bus.sram_web0) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_wmask0[b]) sram_mem[bus.sram_addr0][8*b +: 8] <= bus.sram_din0[8*b +: 8];
        end
        if (!bus.sram_csb1) bus.sram_dout1 <= sram_mem[bus.sram_addr1];
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (m[b]) res[8*b +: 8] = nw[8*b +: 8];
        return res;
    endfunction

    function automatic int sat(input int n);
        return (n > IMEM_DEPTH) ? IMEM_DEPTH : n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [8:0] fa);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = fa;
        #1;
        chk("fetch_csb1", 64'(bus.sram_csb1), 64'd0);
        chk("fetch_addr1", 64'(bus.sram_addr1), 64'(fa));
        tick();
        bus.fetch_req = 1'b0;
        chk("fetch_valid", 64'(bus.fetch_valid), 64'd1);
        chk("fetch_data", 64'(bus.fetch_data), 64'(exp_mem[fa]));
    endtask

    task automatic beat(input logic [8:0] ba, input logic [31:0] bd, input logic [3:0] bm);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = ba;
        bus.ld_data  = bd;
        bus.ld_wmask = bm;
        #1;
        chk("beat_csb0", 64'(bus.sram_csb0), 64'd0);
        chk("beat_web0", 64'(bus.sram_web0), 64'd0);
        chk("beat_addr0", 64'(bus.sram_addr0), 64'(ba));
        chk("beat_din0", 64'(bus.sram_din0), 64'(bd));
        chk("beat_wmask0", 64'(bus.sram_wmask0), 64'(bm));
        tick();
        exp_mem[ba] = merge(exp_mem[ba], bd, bm);
        beats++;
        chk("words_loaded", 64'(bus.words_loaded), 64'(sat(beats)));
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        preload = 1'b1;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            init_mem[i] = $urandom;
            exp_mem[i]  = init_mem[i];
        end
        bus.load_mode  = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;
        bus.ld_wmask   = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        rst_n = 1'b0;
        tick();
        tick();
        preload = 1'b0;
        rst_n   = 1'b1;
        #1;
        chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
        chk("rst_core_stall", 64'(bus.core_stall), 64'd0);
        chk("rst_words", 64'(bus.words_loaded), 64'd0);
        chk("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
        chk("rst_csb0", 64'(bus.sram_csb0), 64'd1);
        chk("rst_web0", 64'(bus.sram_web0), 64'd1);
        chk("rst_csb1", 64'(bus.sram_csb1), 64'd1);

        do_fetch(9'h010);

        for (int i = 0; i < 8; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 9'($urandom_range(0, IMEM_DEPTH - 1));
            bus.fetch_req  = r;
            bus.fetch_addr = a;
            #1;
            chk("rnd_csb1", 64'(bus.sram_csb1), 64'(!r));
            tick();
            chk("rnd_fetch_valid", 64'(bus.fetch_valid), 64'(r));
            if (r) chk("rnd_fetch_data", 64'(bus.fetch_data), 64'(exp_mem[a]));
        end
        bus.fetch_req = 1'b0;
        tick();

        // Load request coinciding with a fetch: that fetch must still be served.
        bus.load_mode  = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 9'h005;
        #1;
        chk("enter_csb1", 64'(bus.sram_csb1), 64'd0);
        chk("enter_addr1", 64'(bus.sram_addr1), 64'h005);
        tick();
        bus.fetch_addr = 9'h007;
        bus.ld_valid   = 1'b1;
        bus.ld_addr    = 9'h040;
        bus.ld_data    = 32'hCAFE0000;
        bus.ld_wmask   = 4'hF;
        #1;
        chk("drain_fetch_valid", 64'(bus.fetch_valid), 64'd1);
        chk("drain_fetch_data", 64'(bus.fetch_data), 64'(exp_mem[9'h005]));
        chk("drain_stall", 64'(bus.core_stall), 64'd1);
        chk("drain_csb1", 64'(bus.sram_csb1), 64'd1);
        chk("drain_ld_ready", 64'(bus.ld_ready), 64'd0);
        chk("drain_csb0", 64'(bus.sram_csb0), 64'd1);
        bus.ld_valid = 1'b0;
        tick();
        #1;
        chk("load_fetch_valid", 64'(bus.fetch_valid), 64'd0);
        chk("load_words0", 64'(bus.words_loaded), 64'd0);
        chk("load_ld_ready", 64'(bus.ld_ready), 64'd1);
        chk("load_stall", 64'(bus.core_stall), 64'd1);
        chk("load_csb1", 64'(bus.sram_csb1), 64'd1);
        bus.fetch_req = 1'b0;

        beats = 0;
        beat(9'h000, 32'hDEADBEEF, 4'hF);
        beat(9'h001, 32'h00000013, 4'hF);
        beat(9'h1FF, 32'h12345678, 4'hF);
        #1;
        chk("words_3", 64'(bus.words_loaded), 64'd3);
        chk("idle_csb0", 64'(bus.sram_csb0), 64'd1);
        chk("idle_web0", 64'(bus.sram_web0), 64'd1);
        chk("idle_addr0", 64'(bus.sram_addr0), 64'd0);
        chk("idle_din0", 64'(bus.sram_din0), 64'd0);
        chk("idle_wmask0", 64'(bus.sram_wmask0), 64'd0);
        beat(9'h020, 32'hFFFFFFFF, 4'hF);
        beat(9'h020, 32'h00AA00BB, 4'h5);
        bus.load_mode = 1'b0;
        beat(9'h030, 32'($urandom), 4'($urandom));

        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 9'h030;
        bus.ld_valid   = 1'b1;
        #1;
        chk("flush_stall", 64'(bus.core_stall), 64'd1);
        chk("flush_csb0", 64'(bus.sram_csb0), 64'd1);
        chk("flush_csb1", 64'(bus.sram_csb1), 64'd1);
        chk("flush_ld_ready", 64'(bus.ld_ready), 64'd0);
        chk("flush_words", 64'(bus.words_loaded), 64'd6);
        bus.ld_valid = 1'b0;
        tick();
        chk("run_fetch_valid", 64'(bus.fetch_valid), 64'd0);
        chk("run_stall", 64'(bus.core_stall), 64'd0);
        bus.fetch_req = 1'b0;

        do_fetch(9'h000);
        chk("rb_deadbeef", 64'(bus.fetch_data), 64'hDEADBEEF);
        do_fetch(9'h001);
        chk("rb_13", 64'(bus.fetch_data), 64'h00000013);
        do_fetch(9'h1FF);
        chk("rb_12345678", 64'(bus.fetch_data), 64'h12345678);
        do_fetch(9'h020);
        chk("rb_masked", 64'(bus.fetch_data), 64'hFFAAFFBB);
        do_fetch(9'h030);
        do_fetch(9'h040);

        // Single-cycle load_mode pulse still runs DRAIN, one LOAD cycle, FLUSH.
        bus.load_mode = 1'b1;
        tick();
        bus.load_mode = 1'b0;
        chk("pulse_drain_stall", 64'(bus.core_stall), 64'd1);
        tick();
        chk("pulse_load_ready", 64'(bus.ld_ready), 64'd1);
        chk("pulse_load_words", 64'(bus.words_loaded), 64'd0);
        beats = 0;
        beat(9'($urandom_range(0, IMEM_DEPTH - 1)), 32'($urandom), 4'($urandom));
        chk("pulse_flush_stall", 64'(bus.core_stall), 64'd1);
        chk("pulse_flush_ready", 64'(bus.ld_ready), 64'd0);
        tick();
        chk("pulse_run_stall", 64'(bus.core_stall), 64'd0);
        chk("pulse_words", 64'(bus.words_loaded), 64'd1);

        // Long window: counter must saturate while writes keep landing.
        bus.load_mode = 1'b1;
        tick();
        tick();
        beats = 0;
        for (int i = 0; i < 600; i++)
            beat(9'($urandom_range(0, IMEM_DEPTH - 1)), 32'($urandom), 4'($urandom));
        chk("sat_words", 64'(bus.words_loaded), 64'd512);

        a = 9'($urandom_range(0, IMEM_DEPTH - 1));
        d = ~exp_mem[a];
        rst_n          = 1'b0;
        bus.ld_valid   = 1'b1;
        bus.ld_addr    = a;
        bus.ld_data    = d;
        bus.ld_wmask   = 4'hF;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        #1;
        chk("rstld_csb0", 64'(bus.sram_csb0), 64'd1);
        chk("rstld_csb1", 64'(bus.sram_csb1), 64'd1);
        tick();
        rst_n         = 1'b1;
        bus.load_mode = 1'b0;
        bus.fetch_req = 1'b0;
        #1;
        chk("rstld_stall", 64'(bus.core_stall), 64'd0);
        chk("rstld_words", 64'(bus.words_loaded), 64'd0);
        chk("rstld_fetch_valid", 64'(bus.fetch_valid), 64'd0);
        chk("rstld_ld_ready", 64'(bus.ld_ready), 64'd0);
        chk("rstld_ignore_csb0", 64'(bus.sram_csb0), 64'd1);
        tick();
        chk("rstld_words_after", 64'(bus.words_loaded), 64'd0);
        bus.ld_valid = 1'b0;
        do_fetch(a);

        for (int i = 0; i < 12; i++) do_fetch(9'($urandom_range(0, IMEM_DEPTH - 1)));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_imem_ctrl
`default_nettype wire
